axis_scope_reader: RTL and testbench

Read-out side of the oscilloscope capture path. After a capture completes, the block walks the circular sample buffer in chronological order, starting from the oldest sample, and streams every word out on an AXI4-Stream master with full backpressure support. It sits between the capture BRAM's second port and the DMA/host stream. The start address is the trigger address reported by the capture block's status word, advanced by one.

---
 rtl/scope_pkg.sv | 18 +
 rtl/axis_scope_reader_fifo2.sv | 58 +++++
 rtl/axis_scope_reader.sv | 127 ++++++++++++
 tb/tb_axis_scope_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and helpers for the scope read-out path.
package scope_pkg;

  localparam int unsigned DEF_TDATA_WIDTH = 32;
  localparam int unsigned DEF_CNTR_WIDTH  = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  // Circular-buffer successor: tot is the last valid address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] tot);
    return (addr == tot) ? '0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/axis_scope_reader_fifo2.sv
// Two-entry register FIFO feeding the AXI4-Stream master; head entry drives the outputs.
module axis_fifo2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_count;
  logic             w_pop;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;
  assign occupancy = r_count;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      unique case ({in_valid, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= in_data;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= in_data;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= in_data;
          end else begin
            r_head <= r_tail;
            r_tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_scope_reader.sv
// Circular capture-buffer read-out onto an AXI4-Stream master.
// Optional tlast output enabled by defining AXIS_SCOPE_READER_TLAST_EN.
module axis_scope_reader
  import scope_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int unsigned CNTR_WIDTH       = DEF_CNTR_WIDTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start_flag,
  input  logic [CNTR_WIDTH-1:0]       start_addr,
  input  logic [CNTR_WIDTH-1:0]       tot_data,
  output logic                        busy,
  output logic [CNTR_WIDTH-1:0]       bram_porta_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] bram_porta_rddata,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
`ifdef AXIS_SCOPE_READER_TLAST_EN
  output logic                        m_axis_tlast,
`endif
  input  logic                        m_axis_tready
);

`ifdef AXIS_SCOPE_READER_TLAST_EN
  localparam int unsigned FIFO_W = AXIS_TDATA_WIDTH + 1;
`else
  localparam int unsigned FIFO_W = AXIS_TDATA_WIDTH;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_start_d;
  logic [CNTR_WIDTH-1:0] r_addr;
  logic [CNTR_WIDTH-1:0] r_tot;
  logic [CNTR_WIDTH:0]   r_remaining;
  logic                  r_inflight;
  logic [1:0]            w_occ;
  logic [2:0]            w_proj;
  logic                  w_fifo_valid;
  logic                  w_pop;
  logic                  w_start;
  logic                  w_issue;
  logic                  w_final_issue;
  logic                  w_drained;
  logic                  w_busy;
  logic [FIFO_W-1:0]     w_fifo_in;
  logic [FIFO_W-1:0]     w_fifo_out;

  assign w_start       = start_flag & ~r_start_d;
  assign w_pop         = w_fifo_valid & m_axis_tready;
  // Credit counts the word leaving this cycle so a steady stream runs bubble-free.
  assign w_proj        = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue       = (r_state == S_READ) && (w_proj < 3'd2);
  assign w_final_issue = w_issue && (r_remaining == (CNTR_WIDTH+1)'(1));
  assign w_drained     = !r_inflight && ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_pop));

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_state_nxt = S_READ;
      end
      S_READ:  if (w_final_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_addr      <= '0;
      r_tot       <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_d  <= start_flag;
      r_inflight <= w_issue;
      if ((r_state == S_IDLE) && w_start) begin
        r_tot       <= tot_data;
        r_addr      <= (start_addr <= tot_data) ? start_addr : '0;
        r_remaining <= {1'b0, tot_data} + (CNTR_WIDTH+1)'(1);
      end else if (w_issue) begin
        r_addr      <= CNTR_WIDTH'(next_addr(32'(r_addr), 32'(r_tot)));
        r_remaining <= r_remaining - (CNTR_WIDTH+1)'(1);
      end
    end
  end

`ifdef AXIS_SCOPE_READER_TLAST_EN
  logic r_inflight_last;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_inflight_last <= 1'b0;
    else          r_inflight_last <= w_final_issue;
  end

  assign w_fifo_in    = {r_inflight_last, bram_porta_rddata};
  assign m_axis_tlast = w_fifo_out[AXIS_TDATA_WIDTH];
`else
  assign w_fifo_in    = bram_porta_rddata;
`endif

  axis_fifo2 #(
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (r_inflight),
    .in_data   (w_fifo_in),
    .out_valid (w_fifo_valid),
    .out_data  (w_fifo_out),
    .out_ready (m_axis_tready),
    .occupancy (w_occ)
  );

  assign busy            = w_busy;
  assign bram_porta_addr = r_addr;
  assign m_axis_tvalid   = w_fifo_valid;
  assign m_axis_tdata    = w_fifo_out[AXIS_TDATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_scope_reader.sv
// Directed bench for axis_scope_reader: table of read-out runs plus reset/start-edge sequences.
module tb_axis_scope_reader;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start_flag;
  logic [11:0] start_addr;
  logic [11:0] tot_data;
  logic        busy;
  logic [11:0] bram_porta_addr;
  logic [31:0] bram_porta_rddata;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        w_tlast;

  axis_scope_reader #(
    .AXIS_TDATA_WIDTH(32),
    .CNTR_WIDTH(12)
  ) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .start_flag        (start_flag),
    .start_addr        (start_addr),
    .tot_data          (tot_data),
    .busy              (busy),
    .bram_porta_addr   (bram_porta_addr),
    .bram_porta_rddata (bram_porta_rddata),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
`ifdef AXIS_SCOPE_READER_TLAST_EN
    .m_axis_tlast      (w_tlast),
`endif
    .m_axis_tready     (m_axis_tready)
  );

`ifndef AXIS_SCOPE_READER_TLAST_EN
  assign w_tlast = 1'b0;
`endif

  always #5 aclk = ~aclk;

  logic [31:0] mem [4096];
  always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

  function automatic logic [31:0] mem_val(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk) begin
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    else            m_axis_tready = 1'b1;
  end

  logic [31:0] cap_data[$];
  int          cap_cyc[$];
  bit          cap_last[$];
  int          stall_err = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;

  // Handshake and hold-stability monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      cap_data.push_back(m_axis_tdata);
      cap_cyc.push_back(cyc);
      cap_last.push_back(w_tlast);
    end
    if (aresetn && prev_stall && (!m_axis_tvalid || (m_axis_tdata !== prev_data)))
      stall_err++;
    prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_run(input logic [11:0] sa, input logic [11:0] td, input logic [11:0] exp_first,
                        input int exp_len, input bit rnd, input bit hold, input bit toggle);
    int start_cyc;
    int budget;
    int busy_fall;
    int errs;
    int a;
    int nlast;
    int nbusy;
    cap_data.delete();
    cap_cyc.delete();
    cap_last.delete();
    stall_err = 0;
    @(posedge aclk); #1;
    rand_ready = rnd;
    start_addr = sa;
    tot_data   = td;
    start_flag = 1'b1;
    start_cyc  = cyc;
    @(posedge aclk); #1;
    if (!hold) start_flag = 1'b0;
    @(negedge aclk);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("first_addr", {52'd0, bram_porta_addr}, {52'd0, exp_first});

    budget    = exp_len * 8 + 50;
    busy_fall = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (toggle) begin
        if (i < 8) start_flag = (i % 2 == 0);
        start_addr = ~sa;
        tot_data   = 12'd2;
      end
      if (!busy) begin
        busy_fall = cyc;
        break;
      end
    end
    start_addr = sa;
    tot_data   = td;
    check("busy_falls_in_budget", {63'd0, busy_fall >= 0}, 64'd1);
    check("word_count", 64'(cap_data.size()), 64'(exp_len));

    errs = 0;
    a    = int'(exp_first);
    for (int k = 0; k < cap_data.size(); k++) begin
      if (cap_data[k] !== mem_val(a)) errs++;
      a = (a == int'(td)) ? 0 : a + 1;
    end
    check("word_sequence_errors", 64'(errs), 64'd0);

    if (cap_data.size() > 0 && busy_fall >= 0) begin
      check("busy_fall_after_last", 64'(busy_fall - cap_cyc[cap_cyc.size()-1]), 64'd1);
      if (!rnd) begin
        check("first_valid_latency", 64'(cap_cyc[0] - start_cyc), 64'd3);
        check("no_bubbles", 64'(cap_cyc[cap_cyc.size()-1] - cap_cyc[0]), 64'(exp_len - 1));
      end
    end
    if (rnd) check("stall_hold_errors", 64'(stall_err), 64'd0);

`ifdef AXIS_SCOPE_READER_TLAST_EN
    nlast = 0;
    foreach (cap_last[k]) if (cap_last[k]) nlast++;
    check("tlast_count", 64'(nlast), 64'd1);
    if (cap_last.size() > 0) check("tlast_on_final", {63'd0, cap_last[cap_last.size()-1]}, 64'd1);
`else
    nlast = 0;
`endif

    if (hold) begin
      nbusy = 0;
      repeat (10) begin
        @(negedge aclk);
        if (busy) nbusy++;
      end
      check("held_start_single_run", 64'(nbusy), 64'd0);
      @(posedge aclk); #1;
      start_flag = 1'b0;
    end
  endtask

  typedef struct {
    logic [11:0] sa;
    logic [11:0] td;
    logic [11:0] exp_first;
    int          exp_len;
    bit          rnd;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{12'd5,    12'd7,    12'd5, 8,    1'b0};
    vecs[1] = '{12'd10,   12'd3,    12'd0, 4,    1'b0};
    vecs[2] = '{12'd0,    12'd0,    12'd0, 1,    1'b0};
    vecs[3] = '{12'd7,    12'd7,    12'd7, 8,    1'b0};
    vecs[4] = '{12'd3,    12'd3,    12'd3, 4,    1'b0};
    vecs[5] = '{12'd0,    12'd4095, 12'd0, 4096, 1'b1};
    vecs[6] = '{12'd2,    12'd5,    12'd2, 6,    1'b1};

    for (int i = 0; i < 4096; i++) mem[i] = mem_val(i);

    aresetn       = 1'b0;
    start_flag    = 1'b0;
    start_addr    = '0;
    tot_data      = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("reset_busy",   {63'd0, busy}, 64'd0);
    check("reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("reset_tdata",  {32'd0, m_axis_tdata}, 64'd0);
    check("reset_addr",   {52'd0, bram_porta_addr}, 64'd0);
`ifdef AXIS_SCOPE_READER_TLAST_EN
    check("reset_tlast",  {63'd0, w_tlast}, 64'd0);
`endif
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < NV; i++)
      do_run(vecs[i].sa, vecs[i].td, vecs[i].exp_first, vecs[i].exp_len, vecs[i].rnd, 1'b0, 1'b0);

    do_run(12'd2, 12'd5, 12'd2, 6, 1'b0, 1'b1, 1'b0);
    do_run(12'd5, 12'd7, 12'd5, 8, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a run, then a clean run.
    cap_data.delete();
    cap_cyc.delete();
    cap_last.delete();
    @(posedge aclk); #1;
    rand_ready = 1'b0;
    start_addr = 12'd0;
    tot_data   = 12'd7;
    start_flag = 1'b1;
    @(posedge aclk); #1;
    start_flag = 1'b0;
    begin
      int b;
      b = 0;
      while (cap_data.size() < 3 && b < 100) begin
        @(negedge aclk);
        b++;
      end
    end
    check("reached_three_words", {63'd0, cap_data.size() >= 3}, 64'd1);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check("midrun_reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("midrun_reset_busy",   {63'd0, busy}, 64'd0);
    check("midrun_reset_addr",   {52'd0, bram_porta_addr}, 64'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    do_run(12'd0, 12'd7, 12'd0, 8, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
